pipelined_addsub: RTL

//   Parametrised, pipelined ripple-carry adder/subtractor. It replaces the fixed 4-bit

---
 rtl/pipelined_addsub.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Purpose  : Parametrised pipelined ripple-carry adder/subtractor. The operands
//            are split into STAGES chunks of WIDTH/STAGES bits; stage k adds
//            chunk k and registers the carry for stage k+1. A single global
//            enable advances every stage at once, giving full backpressure.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready  - operand handshake (A, B, Ci, sub)
//            out_valid/out_ready - result handshake (S, Co, Ovf)
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_addsub #(
  parameter int WIDTH  = 16,  // must be a multiple of STAGES
  parameter int STAGES = 4    // >= 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ovf
);

  localparam int C_CHUNK = WIDTH / STAGES;
  localparam int C_LAST  = STAGES - 1;

  // Per-stage registers. r_a/r_bx carry the full operand words so the
  // not-yet-processed high chunks (and the MSBs needed for overflow) travel
  // with the partial sum in r_s.
  logic             r_v  [STAGES];
  logic [WIDTH-1:0] r_a  [STAGES];
  logic [WIDTH-1:0] r_bx [STAGES];
  logic [WIDTH-1:0] r_s  [STAGES];
  logic             r_c  [STAGES];
  logic             r_ovf;

  // Inputs seen by each stage: ports for stage 0, previous registers otherwise.
  logic [WIDTH-1:0] w_a_src  [STAGES];
  logic [WIDTH-1:0] w_bx_src [STAGES];
  logic [WIDTH-1:0] w_s_src  [STAGES];
  logic             w_c_src  [STAGES];
  logic             w_v_src  [STAGES];
  logic [WIDTH-1:0] w_s_next [STAGES];
  logic             w_c_next [STAGES];
  logic [C_CHUNK:0] w_sum    [STAGES];
  logic             w_ovf_next;
  logic             w_en;

  // Whole pipeline moves when the output slot is empty or being drained.
  assign w_en     = !r_v[C_LAST] || out_ready;
  assign in_ready = w_en;

  always_comb begin
    // Subtraction is A + ~B + 1; the borrow-in flips the injected carry.
    w_a_src[0]  = A;
    w_bx_src[0] = sub ? ~B : B;
    w_s_src[0]  = '0;
    w_c_src[0]  = Ci ^ sub;
    w_v_src[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_a_src[k]  = r_a[k-1];
      w_bx_src[k] = r_bx[k-1];
      w_s_src[k]  = r_s[k-1];
      w_c_src[k]  = r_c[k-1];
      w_v_src[k]  = r_v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_sum[k] = {1'b0, w_a_src[k][k*C_CHUNK +: C_CHUNK]}
               + {1'b0, w_bx_src[k][k*C_CHUNK +: C_CHUNK]}
               + {{C_CHUNK{1'b0}}, w_c_src[k]};
      w_s_next[k] = w_s_src[k];
      w_s_next[k][k*C_CHUNK +: C_CHUNK] = w_sum[k][C_CHUNK-1:0];
      w_c_next[k] = w_sum[k][C_CHUNK];
    end
    // Signed overflow: like-signed operands producing a differently-signed sum.
    w_ovf_next = (w_a_src[C_LAST][WIDTH-1] == w_bx_src[C_LAST][WIDTH-1]) &&
                 (w_s_next[C_LAST][WIDTH-1] != w_a_src[C_LAST][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k]  <= 1'b0;
        r_a[k]  <= '0;
        r_bx[k] <= '0;
        r_s[k]  <= '0;
        r_c[k]  <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_en) begin
      // Bubbles shift along with valid data; nothing is collapsed.
      for (int k = 0; k < STAGES; k++) begin
        r_v[k]  <= w_v_src[k];
        r_a[k]  <= w_a_src[k];
        r_bx[k] <= w_bx_src[k];
        r_s[k]  <= w_s_next[k];
        r_c[k]  <= w_c_next[k];
      end
      r_ovf <= w_ovf_next;
    end
  end

  assign out_valid = r_v[C_LAST];
  assign S         = r_s[C_LAST];
  assign Co        = r_c[C_LAST];
  assign Ovf       = r_ovf;

endmodule
`default_nettype wire
